// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for N requesters with registered one-hot grant, binary index,
// and an optional per-grant hold-time limit that preempts long holders.
module rr_arbiter_8 #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld,
    output logic             preempt
);

    localparam int unsigned HoldW = $clog2(MAX_HOLD) + 1;
    localparam logic [HoldW-1:0] HoldLast =
        (MAX_HOLD != 0) ? HoldW'(MAX_HOLD - 1) : '0;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               preempt_q, preempt_d;
    logic [N-1:0]       grant_q, grant_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [IDX_W-1:0]   cand;

    // N is a power of two, so ptr + k wraps N-1 -> 0 for free.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!pick_vld && req[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en && pick_vld) begin
                    state_d = StGrant;
                    idx_d   = pick_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                // Release wins over timeout when both land on the same edge.
                if (!req[idx_q]) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                end else if ((MAX_HOLD != 0) && (hold_q == HoldLast)) begin
                    state_d   = StIdle;
                    idx_d     = '0;
                    ptr_d     = idx_q + IDX_W'(1);
                    preempt_d = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        grant_d = '0;
        if (state_d == StGrant) begin
            grant_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
            grant_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
            grant_q   <= grant_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign grant_vld = (state_q == StGrant);
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: behavioural round-robin model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rr_arbiter_8;

    localparam int N       = 8;
    localparam int MaxHold = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_vld;
    logic       preempt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter_8 #(
        .N        (N),
        .IDX_W    (3),
        .MAX_HOLD (MaxHold)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .preempt   (preempt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: who holds the resource, how many cycles it has held it, where the scan starts.
    typedef struct {
        bit busy;
        int cur;
        int ptr;
        int cnt;
        bit pre;
    } model_t;

    function automatic model_t model_reset();
        model_t r;
        r.busy = 1'b0;
        r.cur  = 0;
        r.ptr  = 0;
        r.cnt  = 0;
        r.pre  = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(model_t m, logic en_v, logic [7:0] r);
        model_t n = m;
        n.pre = 1'b0;
        if (!m.busy) begin
            if (en_v && r != 8'h00) begin
                for (int k = 0; k < N; k++) begin
                    int i = (m.ptr + k) % N;
                    if (r[i] && !n.busy) begin
                        n.busy = 1'b1;
                        n.cur  = i;
                        n.cnt  = 1;
                    end
                end
            end
        end else if (!r[m.cur]) begin
            n.busy = 1'b0;
            n.ptr  = (m.cur + 1) % N;
        end else if (MaxHold > 0 && m.cnt == MaxHold) begin
            n.busy = 1'b0;
            n.ptr  = (m.cur + 1) % N;
            n.pre  = 1'b1;
        end else begin
            n.cnt = m.cnt + 1;
        end
        return n;
    endfunction

    model_t m;

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_next(m, en, req);
    end

    logic [7:0] exp_grant;
    always @(negedge clk) begin
        if (!rst) begin
            exp_grant = 8'h00;
            if (m.busy) exp_grant[m.cur] = 1'b1;
            check("model_grant", {24'h0, grant}, {24'h0, exp_grant});
            check("model_idx", {29'h0, grant_idx}, m.busy ? m.cur : 0);
            check("model_vld", {31'h0, grant_vld}, {31'h0, m.busy});
            check("model_preempt", {31'h0, preempt}, {31'h0, m.pre});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 8'h00;
        en  = 1'b0;
        @(negedge clk);
        check("rst_grant", {24'h0, grant}, 0);
        check("rst_idx", {29'h0, grant_idx}, 0);
        check("rst_vld", {31'h0, grant_vld}, 0);
        check("rst_preempt", {31'h0, preempt}, 0);
        rst = 1'b0;
    endtask

    int n;
    int len;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request, one-edge latency.
        do_reset();
        req = 8'b0000_0100;
        en  = 1'b1;
        @(negedge clk);
        check("t1_grant", {24'h0, grant}, 32'h04);
        check("t1_idx", {29'h0, grant_idx}, 2);
        check("t1_vld", {31'h0, grant_vld}, 1);
        req = 8'h00;
        @(negedge clk);

        // All requesting: rotation with 16-cycle timeouts and one idle gap.
        do_reset();
        req = 8'hFF;
        en  = 1'b1;
        for (int g = 0; g < 9; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!grant_vld && n < 5);
            check("t2_gap", n, 1);
            check("t2_idx", {29'h0, grant_idx}, g % N);
            len = 1;
            forever begin
                @(negedge clk);
                if (!grant_vld || len > 40) break;
                len++;
            end
            check("t2_len", len, MaxHold);
            check("t2_preempt", {31'h0, preempt}, 1);
        end
        req = 8'h00;
        @(negedge clk);

        // Release from idx 7 wraps the pointer to 0.
        do_reset();
        req = 8'h80;
        en  = 1'b1;
        @(negedge clk);
        check("t3_idx7", {29'h0, grant_idx}, 7);
        req = 8'b0000_0011;
        @(negedge clk);
        check("t3_gap_vld", {31'h0, grant_vld}, 0);
        check("t3_gap_preempt", {31'h0, preempt}, 0);
        @(negedge clk);
        check("t3_grant0", {24'h0, grant}, 32'h01);
        check("t3_preempt", {31'h0, preempt}, 0);
        req = 8'h00;
        @(negedge clk);

        // Async reset mid-grant restores the pointer to 0.
        do_reset();
        req = 8'h20;
        en  = 1'b1;
        @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        req = 8'h08;
        @(negedge clk);
        check("t4_idx3", {29'h0, grant_idx}, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t4_async_grant", {24'h0, grant}, 0);
        check("t4_async_vld", {31'h0, grant_vld}, 0);
        @(negedge clk);
        rst = 1'b0;
        req = 8'h88;
        @(negedge clk);
        check("t4_after_rst_idx", {29'h0, grant_idx}, 3);
        req = 8'h00;
        @(negedge clk);

        // en gates only new grants.
        req = 8'h10;
        en  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("t5_blocked", {31'h0, grant_vld}, 0);
        end
        en = 1'b1;
        @(negedge clk);
        check("t5_grant", {24'h0, grant}, 32'h10);
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t5_held", {24'h0, grant}, 32'h10);
        end
        req = 8'h00;
        @(negedge clk);
        check("t5_release", {31'h0, grant_vld}, 0);

        // Release on the timeout edge counts as release.
        req = 8'h01;
        en  = 1'b1;
        @(negedge clk);
        check("t6_grant", {24'h0, grant}, 32'h01);
        repeat (MaxHold - 1) @(negedge clk);
        check("t6_still", {31'h0, grant_vld}, 1);
        req = 8'h00;
        @(negedge clk);
        check("t6_vld", {31'h0, grant_vld}, 0);
        check("t6_preempt", {31'h0, preempt}, 0);

        // Random sticky requests against the model.
        do_reset();
        req = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 199) == 0) req = 8'h00;
            en = ($urandom_range(0, 9) != 0);
        end
        req = 8'h00;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
